// File: rtl/alu_result_rx.sv
// ALU result receiver: checks parity on incoming result bytes, queues good words in a
// first-word-fall-through FIFO, drops bad words and tracks them with a sticky flag and counter.
module alu_result_rx #(
    parameter int DEPTH       = 4,
    parameter bit HALT_ON_ERR = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              alu_in,
    input  logic                    parity_in,
    input  logic [2:0]              sel_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic [2:0]              out_sel,
    input  logic                    clear_err,
    output logic                    par_err,
    output logic [7:0]              err_cnt,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e          state_q;
    logic            par_err_q;
    logic [7:0]      err_cnt_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [10:0]     mem_q [DEPTH];
    logic [10:0]     head;

    logic accept;
    logic parity_ok;
    logic push;
    logic pop;
    logic bad_accept;

    // in_ready is gated by rst so nothing can be accepted on an edge where reset is high.
    assign in_ready   = ~rst & (state_q == RUN) & (count_q < CW'(DEPTH));
    assign accept     = in_valid & in_ready;
    assign parity_ok  = ((^alu_in) == parity_in);
    assign push       = accept & parity_ok;
    assign bad_accept = accept & ~parity_ok;
    assign pop        = out_valid & out_ready;

    assign out_valid  = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign out_data   = out_valid ? head[7:0]  : '0;
    assign out_sel    = out_valid ? head[10:8] : '0;
    assign fifo_count = count_q;
    assign par_err    = par_err_q;
    assign err_cnt    = err_cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sel_in, alu_in};
        end
    end

    // clear_err takes priority over a simultaneous bad accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            par_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else if (clear_err) begin
            state_q   <= RUN;
            par_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else if (bad_accept) begin
            par_err_q <= 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (HALT_ON_ERR) begin
                state_q <= HALT;
            end
        end
    end

endmodule
